// File: rtl/arps_mv_capture.sv
// arps_mv_capture: snoops the ARPS core's MV BRAM write port, captures each
// full-word motion-vector write of one frame into a FIFO and streams the
// vectors out on a valid/ready port tagged with their word index.
// The output register is the head slot of the FIFO, so the output register
// plus the storage array together hold at most FIFO_DEPTH entries.
module arps_mv_capture #(
    parameter int MB_COUNT   = 396,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        en_mv,
    input  logic [3:0]  we_mv,
    input  logic [31:0] addr_mv,
    input  logic [31:0] data_mv,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [15:0] m_index,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        order_err,
    output logic        partial_err,
    output logic [15:0] mv_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [47:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_data_q, m_data_d;
    logic [15:0]   m_index_q, m_index_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic          order_err_q, order_err_d;
    logic          partial_err_q, partial_err_d;
    logic [15:0]   mv_count_q, mv_count_d;
    logic [15:0]   exp_idx_q, exp_idx_d;

    logic          wr_evt_s;
    logic          full_wr_s;
    logic          part_wr_s;
    logic [CW-1:0] occ_s;
    logic          fifo_full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          load_s;
    logic [15:0]   wr_idx_s;
    logic [47:0]   head_s;
    logic          unused_addr_s;

    // Only the word index bits of the byte address carry information here.
    assign unused_addr_s = ^{addr_mv[31:18], addr_mv[1:0]};

    assign wr_idx_s    = addr_mv[17:2];
    assign wr_evt_s    = (state_q == ST_CAPTURE) && en_mv && (we_mv != 4'h0);
    assign full_wr_s   = wr_evt_s && (we_mv == 4'hF);
    assign part_wr_s   = wr_evt_s && (we_mv != 4'hF);
    // Occupancy counts the output slot as one of the FIFO entries.
    assign occ_s       = mem_cnt_q + CW'(m_valid_q);
    assign fifo_full_s = (occ_s == CW'(FIFO_DEPTH));
    assign pop_s       = m_valid_q && m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_s      = full_wr_s && (!fifo_full_s || pop_s);
    assign drop_s      = full_wr_s && fifo_full_s && !pop_s;
    // Refill the output slot from storage when it is empty or being consumed.
    assign load_s      = (mem_cnt_q != {CW{1'b0}}) && (!m_valid_q || pop_s);
    assign head_s      = mem_q[rd_ptr_q];

    // Next-state logic: FIFO movement, frame FSM, counters and sticky flags.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_cnt_d     = mem_cnt_q + CW'(push_s) - CW'(load_s);
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_index_d     = m_index_q;
        overflow_d    = overflow_q;
        order_err_d   = order_err_q;
        partial_err_d = partial_err_q;
        mv_count_d    = mv_count_q;
        exp_idx_d     = exp_idx_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (load_s) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            m_valid_d = 1'b1;
            m_data_d  = head_s[47:16];
            m_index_d = head_s[15:0];
        end else if (pop_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_CAPTURE;
                    wr_ptr_d      = {AW{1'b0}};
                    rd_ptr_d      = {AW{1'b0}};
                    mem_cnt_d     = {CW{1'b0}};
                    m_valid_d     = 1'b0;
                    m_data_d      = 32'h0000_0000;
                    m_index_d     = 16'h0000;
                    overflow_d    = 1'b0;
                    order_err_d   = 1'b0;
                    partial_err_d = 1'b0;
                    mv_count_d    = 16'h0000;
                    exp_idx_d     = 16'h0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (wr_evt_s) begin
                    mv_count_d = (mv_count_q == 16'hFFFF) ? mv_count_q : (mv_count_q + 16'd1);
                end else begin
                    mv_count_d = mv_count_q;
                end
                if (full_wr_s) begin
                    if (wr_idx_s != exp_idx_q) begin
                        order_err_d = 1'b1;
                    end else begin
                        order_err_d = order_err_q;
                    end
                    exp_idx_d = wr_idx_s + 16'd1;
                    if (drop_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                end else if (part_wr_s) begin
                    partial_err_d = 1'b1;
                end else begin
                    exp_idx_d = exp_idx_q;
                end
                if (mv_count_d >= 16'(MB_COUNT)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (occ_s == {CW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_CAPTURE) || (state_d == ST_DRAIN);
        frame_done_d = (state_d == ST_DONE);
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            mem_cnt_q     <= {CW{1'b0}};
            m_valid_q     <= 1'b0;
            m_data_q      <= 32'h0000_0000;
            m_index_q     <= 16'h0000;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            order_err_q   <= 1'b0;
            partial_err_q <= 1'b0;
            mv_count_q    <= 16'h0000;
            exp_idx_q     <= 16'h0000;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_cnt_q     <= mem_cnt_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_index_q     <= m_index_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            order_err_q   <= order_err_d;
            partial_err_q <= partial_err_d;
            mv_count_q    <= mv_count_d;
            exp_idx_q     <= exp_idx_d;
        end
    end

    // FIFO storage array; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {data_mv, wr_idx_s};
        end
    end

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_index     = m_index_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign order_err   = order_err_q;
    assign partial_err = partial_err_q;
    assign mv_count    = mv_count_q;

endmodule

// File: tb/tb_arps_mv_capture.sv
// Testbench for arps_mv_capture: directed scenarios plus randomized frames
// checked against a queue-based model of the capture/stream behaviour.
module tb_arps_mv_capture;

    localparam int MB = 6;
    localparam int D  = 4;

    typedef struct {
        logic [15:0] idx;
        logic [31:0] dat;
        int          e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        en_mv = 1'b0;
    logic [3:0]  we_mv = 4'h0;
    logic [31:0] addr_mv = 32'h0;
    logic [31:0] data_mv = 32'h0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic [15:0] m_index;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        order_err;
    logic        partial_err;
    logic [15:0] mv_count;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int fd_cnt = 0;
    logic [15:0] pop_idx[$];
    logic [31:0] pop_dat[$];

    arps_mv_capture #(.MB_COUNT(MB), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .en_mv(en_mv), .we_mv(we_mv),
        .addr_mv(addr_mv), .data_mv(data_mv), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .order_err(order_err), .partial_err(partial_err),
        .mv_count(mv_count)
    );

    always #5 clk = ~clk;

    // Record frame_done pulses and every handshake that will pop at the next edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt++;
        if (m_valid === 1'b1 && m_ready === 1'b1 && rst === 1'b1) begin
            pop_idx.push_back(m_index);
            pop_dat.push_back(m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    task automatic set_wr(input logic e, input logic [3:0] we, input logic [15:0] idx, input logic [31:0] d);
        en_mv   = e;
        we_mv   = we;
        addr_mv = {14'd0, idx, 2'b00};
        data_mv = d;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy === 1'b1; i++) tick();
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({m_valid, busy, frame_done, overflow, order_err, partial_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 000000",
                     {m_valid, busy, frame_done, overflow, order_err, partial_err});
        end
        checks++;
        if (mv_count !== 16'd0 || m_data !== 32'd0 || m_index !== 16'd0) begin
            errors++;
            $display("FAIL reset_data cnt=%0d data=%h idx=%0d required 0", mv_count, m_data, m_index);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        int fd0;
        fd0 = fd_cnt;
        pop_idx.delete();
        pop_dat.delete();
        m_ready = 1'b1;
        do_start();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nom_busy got %b required 1", busy);
        end
        for (int i = 0; i < MB; i++) begin
            set_wr(1'b1, 4'hF, 16'(i), 32'hA0 + 32'(i));
            tick();
            checks++;
            if (i == 0 ? (m_valid !== 1'b0)
                       : (m_valid !== 1'b1 || m_index !== 16'(i - 1) || m_data !== 32'hA0 + 32'(i - 1))) begin
                errors++;
                $display("FAIL nom_latency w=%0d got v=%b i=%0d d=%h", i, m_valid, m_index, m_data);
            end
        end
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_index !== 16'd5 || m_data !== 32'hA5) begin
            errors++;
            $display("FAIL nom_last got v=%b i=%0d d=%h required 1/5/a5", m_valid, m_index, m_data);
        end
        wait_idle();
        checks++;
        if (pop_idx.size() != MB) begin
            errors++;
            $display("FAIL nom_count got %0d required %0d", pop_idx.size(), MB);
        end else begin
            for (int i = 0; i < MB; i++) begin
                checks++;
                if (pop_idx[i] !== 16'(i) || pop_dat[i] !== 32'hA0 + 32'(i)) begin
                    errors++;
                    $display("FAIL nom_order n=%0d got %0d/%h required %0d/%h",
                             i, pop_idx[i], pop_dat[i], i, 32'hA0 + 32'(i));
                end
            end
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL nom_frame_done got %0d pulses required 1", fd_cnt - fd0);
        end
        checks++;
        if ({overflow, order_err, partial_err} !== 3'b0 || mv_count !== 16'd6) begin
            errors++;
            $display("FAIL nom_flags got %b cnt=%0d required 000 cnt=6",
                     {overflow, order_err, partial_err}, mv_count);
        end
    endtask

    task automatic test_overflow();
        int fd0;
        fd0 = fd_cnt;
        pop_idx.delete();
        pop_dat.delete();
        m_ready = 1'b0;
        do_start();
        for (int i = 0; i < MB; i++) begin
            set_wr(1'b1, 4'hF, 16'(i), 32'hB0 + 32'(i));
            tick();
        end
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        tick();
        checks++;
        if (overflow !== 1'b1 || mv_count !== 16'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got ovf=%b cnt=%0d busy=%b required 1/6/1", overflow, mv_count, busy);
        end
        m_ready = 1'b1;
        wait_idle();
        checks++;
        if (pop_idx.size() != D) begin
            errors++;
            $display("FAIL ovf_count got %0d required %0d", pop_idx.size(), D);
        end else begin
            for (int i = 0; i < D; i++) begin
                checks++;
                if (pop_idx[i] !== 16'(i) || pop_dat[i] !== 32'hB0 + 32'(i)) begin
                    errors++;
                    $display("FAIL ovf_order n=%0d got %0d/%h", i, pop_idx[i], pop_dat[i]);
                end
            end
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL ovf_frame_done got %0d required 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_full_pop();
        pop_idx.delete();
        pop_dat.delete();
        m_ready = 1'b0;
        do_start();
        for (int i = 0; i < D; i++) begin
            set_wr(1'b1, 4'hF, 16'(i), 32'hC0 + 32'(i));
            tick();
        end
        set_wr(1'b1, 4'hF, 16'd4, 32'hC4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        checks++;
        if (overflow !== 1'b0 || m_valid !== 1'b1 || m_index !== 16'd1) begin
            errors++;
            $display("FAIL fullpop_ovf got ovf=%b v=%b i=%0d required 0/1/1", overflow, m_valid, m_index);
        end
        set_wr(1'b1, 4'h3, 16'd5, 32'hC5);
        tick();
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        checks++;
        if (partial_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_partial got pe=%b busy=%b required 1/1", partial_err, busy);
        end
        m_ready = 1'b1;
        wait_idle();
        checks++;
        if (pop_idx.size() != 5) begin
            errors++;
            $display("FAIL fullpop_count got %0d required 5", pop_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pop_idx[i] !== 16'(i) || pop_dat[i] !== 32'hC0 + 32'(i)) begin
                    errors++;
                    $display("FAIL fullpop_order n=%0d got %0d/%h", i, pop_idx[i], pop_dat[i]);
                end
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_final_ovf got %b required 0", overflow);
        end
    endtask

    task automatic test_faults();
        logic [15:0] exp_i[5];
        exp_i = '{16'd0, 16'd2, 16'd3, 16'd4, 16'd5};
        pop_idx.delete();
        pop_dat.delete();
        m_ready = 1'b1;
        do_start();
        set_wr(1'b1, 4'h3, 16'd0, 32'hD0);
        tick();
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        checks++;
        if (partial_err !== 1'b1 || mv_count !== 16'd1 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL flt_partial got pe=%b cnt=%0d oe=%b required 1/1/0", partial_err, mv_count, order_err);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL flt_nopush got v=%b required 0", m_valid);
        end
        for (int i = 0; i < 5; i++) begin
            set_wr(1'b1, 4'hF, exp_i[i], 32'hE0 + 32'(exp_i[i]));
            tick();
        end
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL flt_order got %b required 1", order_err);
        end
        wait_idle();
        checks++;
        if (pop_idx.size() != 5) begin
            errors++;
            $display("FAIL flt_count got %0d required 5", pop_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pop_idx[i] !== exp_i[i] || pop_dat[i] !== 32'hE0 + 32'(exp_i[i])) begin
                    errors++;
                    $display("FAIL flt_out n=%0d got %0d/%h required %0d", i, pop_idx[i], pop_dat[i], exp_i[i]);
                end
            end
        end
    endtask

    task automatic test_control();
        int fd0;
        fd0 = fd_cnt;
        m_ready = 1'b0;
        do_start();
        set_wr(1'b1, 4'hF, 16'd0, 32'hF0);
        tick();
        set_wr(1'b1, 4'hF, 16'd1, 32'hF1);
        tick();
        start = 1'b1;
        set_wr(1'b1, 4'hF, 16'd2, 32'hF2);
        tick();
        start = 1'b0;
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        checks++;
        if (busy !== 1'b1 || mv_count !== 16'd3 || m_valid !== 1'b1 || m_index !== 16'd0) begin
            errors++;
            $display("FAIL ctl_restart got busy=%b cnt=%0d v=%b i=%0d required 1/3/1/0",
                     busy, mv_count, m_valid, m_index);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || mv_count !== 16'd0) begin
            errors++;
            $display("FAIL ctl_reset got v=%b busy=%b cnt=%0d required 0/0/0", m_valid, busy, mv_count);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        pop_idx.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, 4'hF, 16'(i), 32'h10 + 32'(i));
            tick();
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL ctl_idle_write n=%0d got v=%b required 0", i, m_valid);
            end
        end
        set_wr(1'b0, 4'h0, 16'd0, 32'd0);
        tick();
        tick();
        checks++;
        if (mv_count !== 16'd0 || pop_idx.size() != 0 || fd_cnt != fd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ctl_idle got cnt=%0d pops=%0d fd=%0d busy=%b required 0/0/0/0",
                     mv_count, pop_idx.size(), fd_cnt - fd0, busy);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t ent;
        int fd0, mcnt, thr, sz, r;
        logic [15:0] mexp, nxt, idx;
        logic mov, moe, mpe, cap, exp_v, pop, en;
        logic [3:0] we;
        for (int f = 0; f < 3; f++) begin
            fd0 = fd_cnt;
            q.delete();
            mcnt = 0; mexp = 16'd0; nxt = 16'd0;
            mov = 1'b0; moe = 1'b0; mpe = 1'b0; cap = 1'b1;
            thr = (f == 1) ? 1 : 3;
            set_wr(1'b0, 4'h0, 16'd0, 32'd0);
            do_start();
            for (int c = 0; c < 3000 && (cap || q.size() != 0); c++) begin
                exp_v = (q.size() > 0) && (q[0].e <= ecnt - 1);
                checks++;
                if (m_valid !== exp_v || (exp_v && (m_index !== q[0].idx || m_data !== q[0].dat))) begin
                    errors++;
                    $display("FAIL rnd_out f=%0d c=%0d got v=%b i=%0d d=%h required v=%b i=%0d d=%h",
                             f, c, m_valid, m_index, m_data, exp_v,
                             exp_v ? q[0].idx : 16'd0, exp_v ? q[0].dat : 32'd0);
                end
                m_ready = ($urandom_range(0, 3) < thr);
                en = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                we = (r == 0) ? 4'h3 : ((r == 1) ? 4'h0 : 4'hF);
                idx = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 400)) : nxt;
                set_wr(en, we, idx, $urandom);
                pop = exp_v && m_ready;
                sz = q.size();
                if (pop) void'(q.pop_front());
                if (cap && en && we != 4'h0) begin
                    if (mcnt < 65535) mcnt++;
                    if (we == 4'hF) begin
                        if (idx != mexp) moe = 1'b1;
                        mexp = idx + 16'd1;
                        nxt = idx + 16'd1;
                        if (sz < D || pop) begin
                            ent.idx = idx; ent.dat = data_mv; ent.e = ecnt + 1;
                            q.push_back(ent);
                        end else begin
                            mov = 1'b1;
                        end
                    end else begin
                        mpe = 1'b1;
                    end
                    if (mcnt >= MB) cap = 1'b0;
                end
                tick();
            end
            set_wr(1'b0, 4'h0, 16'd0, 32'd0);
            m_ready = 1'b1;
            checks++;
            if (cap || q.size() != 0) begin
                errors++;
                $display("FAIL rnd_timeout f=%0d pending=%0d", f, q.size());
            end
            wait_idle();
            checks++;
            if (fd_cnt - fd0 != 1) begin
                errors++;
                $display("FAIL rnd_frame_done f=%0d got %0d required 1", f, fd_cnt - fd0);
            end
            checks++;
            if ({overflow, order_err, partial_err} !== {mov, moe, mpe} || mv_count !== 16'(mcnt)) begin
                errors++;
                $display("FAIL rnd_flags f=%0d got %b cnt=%0d required %b cnt=%0d",
                         f, {overflow, order_err, partial_err}, mv_count, {mov, moe, mpe}, mcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_full_pop();
        test_faults();
        test_control();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arps_mv_capture.md
# arps_mv_capture

Downstream companion of the ARPS motion-estimation core. It snoops the core's motion-vector BRAM write port (`*_mv` signals), captures every full-word MV write of one frame into an internal FIFO, and streams the vectors out on a valid/ready port tagged with their macroblock index. It also flags protocol faults and signals end of frame. It sits between the ARPS core's MV BRAM port and the downstream MV consumer (DMA or checker), and is started by the AXI-lite control path.

## Interface
- `MB_COUNT`, 396: motion vectors expected per frame (22x18 macroblocks at 352x288).
- `FIFO_DEPTH`, 16: capture FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that arms capture of a new frame.
- `en_mv` in 1: MV BRAM enable from the ARPS core.
- `we_mv` in 4: MV BRAM byte write enables.
- `addr_mv` in 32: MV BRAM byte address.
- `data_mv` in 32: MV BRAM write data.
- `m_valid` out 1: output vector valid.
- `m_ready` in 1: downstream ready.
- `m_data` out 32: captured vector word.
- `m_index` out 16: word index of the vector (`addr_mv[17:2]`).
- `busy` out 1: high in CAPTURE or DRAIN.
- `frame_done` out 1: one-cycle pulse when the frame has been fully delivered.
- `overflow` out 1: sticky; a write was dropped because the FIFO was full.
- `order_err` out 1: sticky; a write's index did not match the expected sequence.
- `partial_err` out 1: sticky; a write had `we_mv` other than 0000 or 1111.
- `mv_count` out 16: writes seen this frame, including dropped ones.

## Operation
- States are IDLE, CAPTURE, DRAIN and DONE.
- IDLE:
  - All writes are ignored.
  - `start` moves to CAPTURE and clears `mv_count`, the expected index, the FIFO and all sticky flags.
- CAPTURE:
  - A write event is `en_mv && we_mv != 0`.
  - If `we_mv == 4'hF`, the write is pushed as {data, `addr_mv[17:2]`}.
  - Any other nonzero `we_mv` sets `partial_err`. The write is not pushed but is still counted.
  - Every write event increments `mv_count`.
  - If the pushed index differs from the expected index, `order_err` is set. The entry is still pushed, and the expected index becomes the written index + 1.
  - Pushing while the FIFO is full and no pop happens in that cycle sets `overflow` and drops the write.
  - When `mv_count` reaches `MB_COUNT`, the state moves to DRAIN. The transition happens in the same cycle the count register is updated.
- DRAIN:
  - Write events are ignored and not counted.
  - When the FIFO is empty, the state moves to DONE.
- DONE:
  - `frame_done` is high for exactly one cycle.
  - The next state is IDLE.
- `start` outside IDLE is ignored.
- `mv_count` saturates at 0xFFFF.
- Sticky flags hold until the next accepted `start` or reset.

## Timing
- Reset values:
  - State is IDLE.
  - `m_valid`, `busy`, `frame_done`, `overflow`, `order_err` and `partial_err` are 0.
  - `mv_count` is 0.
  - `m_data` and `m_index` are 0.
  - The FIFO is empty.
- Reset asserted mid-frame empties the FIFO immediately and returns to IDLE. No `frame_done` is produced.
- The `start` pulse at edge N gives `busy` = 1 from N+1. Writes are captured from edge N+1.
- Push-to-output latency is 1 cycle: a write sampled at edge N gives `m_valid` = 1 after N+1 when the FIFO was empty.
- The output is FIFO-held. `m_data` and `m_index` stay stable while `m_valid && !m_ready`. A pop occurs on `m_valid && m_ready`.
- Sustained throughput is one push and one pop per cycle. A simultaneous push and pop on a full FIFO succeeds with no overflow.
- If the `MB_COUNT`-th write is sampled at edge N, the state is DRAIN from N+1. When the FIFO is seen empty at edge M, DONE is entered at M+1, `frame_done` is high for cycle M+1, and IDLE follows at M+2.
- The core writes at most one word per cycle. Back-to-back writes every cycle must be captured.

## Test plan
- Nominal frame: `MB_COUNT`=4, `FIFO_DEPTH`=4, `m_ready`=1. `start`, then writes to addresses 0x0, 0x4, 0x8, 0xC with data 0xA0..0xA3 → outputs with index 0..3 and data 0xA0..0xA3 in order, each 1 cycle after its write. Exactly one `frame_done` pulse. All flags 0.
- Backpressure/overflow: `FIFO_DEPTH`=4, `m_ready`=0, 6 consecutive full writes → `overflow`=1 and `mv_count`=6. After `m_ready`=1 the first 4 entries drain in order, then `frame_done` (with `MB_COUNT`=6).
- Full with simultaneous pop: FIFO at 4/4, `m_ready`=1 and a write in the same cycle → no overflow, and the FIFO stays at 4.
- Faults: a write with `we_mv`=0011 → `partial_err`=1, nothing pushed, `mv_count`+1. Writes to index 0 then 2 → `order_err`=1 and both pushed.
- Control: `start` during CAPTURE is ignored and the counters are kept. `rst`=0 asserted mid-frame with 3 entries queued → `m_valid`=0 immediately, IDLE, no `frame_done`. Writes in IDLE produce no output.
